// File: rtl/usb_tx_pkg.sv
// Shared USB transmit definitions: packet command types, PID values and scheduler states.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        OUT   = 3'b000,
        IN    = 3'b001,
        DATA0 = 3'b010,
        DATA1 = 3'b011,
        ACK   = 3'b100,
        NAK   = 3'b101,
        STALL = 3'b110
    } tx_packet_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_ACTIVE,
        S_GAP
    } sched_state_t;

    // Full PID byte as sent on the wire: check nibble in the upper half.
    function automatic logic [7:0] pid_byte(input tx_packet_t t);
        logic [3:0] pid;
        case (t)
            IN:      pid = PID_IN;
            DATA0:   pid = PID_DATA0;
            DATA1:   pid = PID_DATA1;
            ACK:     pid = PID_ACK;
            NAK:     pid = PID_NAK;
            STALL:   pid = PID_STALL;
            default: pid = PID_OUT;
        endcase
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/sched_timer.sv
// Saturating cycle counter with clear/enable and a terminal-count flag for the scheduler.
module sched_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] count;
    logic [WIDTH:0]   count_inc;

    // tc flags that the current enabled clock completes 'limit' counted clocks.
    assign count_inc = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
    assign tc        = (count_inc >= {1'b0, limit});

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count_inc[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Arbitrates handshake and data transmit requests, issues packet commands to txcu,
// supervises start timeout and inter-packet gap, and tracks the DATA0/DATA1 toggle.
module tx_scheduler
    import usb_tx_pkg::*;
#(
    parameter int unsigned GAP_CYCLES    = 16,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       hs_req,
    input  logic [2:0] hs_type,
    input  logic       data_req,
    input  logic [6:0] data_len,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    input  logic       rx_ack,
    input  logic       clr_toggle,
    output logic [2:0] tx_packet,
    output logic       hs_grant,
    output logic       data_grant,
    output logic       done,
    output logic       sched_error,
    output logic       busy
);

    localparam logic [7:0] GAP_LIM   = 8'(GAP_CYCLES);
    localparam logic [7:0] START_LIM = 8'(START_TIMEOUT);

    sched_state_t state;
    tx_packet_t   pkt_q;
    tx_packet_t   latched;
    logic         toggle;
    logic         sent_data;
    logic         err_flag;

    logic         take_hs;
    logic         take_data;
    logic         tmr_clear;
    logic         tmr_enable;
    logic         tmr_tc;
    logic [7:0]   tmr_limit;

    assign tx_packet = pkt_q;

    always_comb begin
        take_hs    = (state == S_IDLE) && hs_req;
        take_data  = (state == S_IDLE) && !hs_req && data_req && (buffer_occupancy >= data_len);
        tmr_enable = (state == S_ISSUE) || (state == S_GAP);
        tmr_clear  = (state == S_IDLE) || (state == S_ACTIVE) || ((state == S_ISSUE) && tmr_tc);
        tmr_limit  = (state == S_GAP) ? GAP_LIM : START_LIM;
    end

    sched_timer #(
        .WIDTH (8)
    ) u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .limit  (tmr_limit),
        .tc     (tmr_tc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            pkt_q       <= OUT;
            latched     <= OUT;
            hs_grant    <= 1'b0;
            data_grant  <= 1'b0;
            done        <= 1'b0;
            sched_error <= 1'b0;
            busy        <= 1'b0;
            err_flag    <= 1'b0;
        end else begin
            hs_grant    <= 1'b0;
            data_grant  <= 1'b0;
            done        <= 1'b0;
            sched_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take_hs) begin
                        latched  <= tx_packet_t'(hs_type);
                        hs_grant <= 1'b1;
                        state    <= S_ISSUE;
                        busy     <= 1'b1;
                    end else if (take_data) begin
                        latched    <= toggle ? DATA1 : DATA0;
                        data_grant <= 1'b1;
                        state      <= S_ISSUE;
                        busy       <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // Only accept 'active' once the command has actually been presented.
                    if (tx_transfer_active && (pkt_q != OUT)) begin
                        pkt_q <= OUT;
                        state <= S_ACTIVE;
                    end else if (tmr_tc) begin
                        pkt_q       <= OUT;
                        sched_error <= 1'b1;
                        state       <= S_GAP;
                    end else begin
                        pkt_q <= latched;
                    end
                end
                S_ACTIVE: begin
                    if (!tx_transfer_active) begin
                        done        <= 1'b1;
                        sched_error <= err_flag | tx_error;
                        err_flag    <= 1'b0;
                        state       <= S_GAP;
                    end else if (tx_error) begin
                        err_flag <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (tmr_tc) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    pkt_q <= OUT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A grant in the same cycle as a valid rx_ack re-arms sent_data for the new packet.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            toggle    <= 1'b0;
            sent_data <= 1'b0;
        end else if (clr_toggle) begin
            toggle    <= 1'b0;
            sent_data <= 1'b0;
        end else begin
            if (rx_ack && sent_data) begin
                toggle <= ~toggle;
            end
            sent_data <= take_data | (sent_data & ~rx_ack);
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// Self-checking bench for tx_scheduler: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_tx_scheduler;
    import usb_tx_pkg::*;

    localparam int GAP = 16;
    localparam int STO = 8;
    localparam int GAP_LEN = (GAP < 1) ? 1 : GAP;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       hs_req;
    logic [2:0] hs_type;
    logic       data_req;
    logic [6:0] data_len;
    logic [6:0] buffer_occupancy;
    logic       tx_transfer_active;
    logic       tx_error;
    logic       rx_ack;
    logic       clr_toggle;
    logic [2:0] tx_packet;
    logic       hs_grant;
    logic       data_grant;
    logic       done;
    logic       sched_error;
    logic       busy;

    always #5 clk = ~clk;

    tx_scheduler #(
        .GAP_CYCLES    (GAP),
        .START_TIMEOUT (STO)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .hs_req             (hs_req),
        .hs_type            (hs_type),
        .data_req           (data_req),
        .data_len           (data_len),
        .buffer_occupancy   (buffer_occupancy),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .rx_ack             (rx_ack),
        .clr_toggle         (clr_toggle),
        .tx_packet          (tx_packet),
        .hs_grant           (hs_grant),
        .data_grant         (data_grant),
        .done               (done),
        .sched_error        (sched_error),
        .busy               (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- txcu stand-in ----------------
    int txcu_delay = 2;
    int txcu_len   = 20;
    bit txcu_err   = 0;
    bit force_mute = 0;
    bit rand_txcu  = 0;

    initial begin
        int d, l, ea;
        bit mute;
        tx_transfer_active = 1'b0;
        tx_error           = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (n_rst === 1'b1 && tx_packet != 3'b000) begin
                mute = force_mute || (rand_txcu && $urandom_range(0, 7) == 0);
                if (rand_txcu) begin
                    d  = $urandom_range(1, 3);
                    l  = $urandom_range(1, 12);
                    ea = ($urandom_range(0, 4) == 0) ? $urandom_range(0, l - 1) : -1;
                end else begin
                    d  = txcu_delay;
                    l  = txcu_len;
                    ea = txcu_err ? l / 2 : -1;
                end
                if (mute) begin
                    for (int k = 0; k < 40 && tx_packet != 3'b000 && n_rst; k++) begin
                        @(posedge clk); #1;
                    end
                end else begin
                    for (int k = 1; k < d && n_rst; k++) begin
                        @(posedge clk); #1;
                    end
                    if (n_rst) begin
                        tx_transfer_active = 1'b1;
                        for (int k = 0; k < l && n_rst; k++) begin
                            tx_error = (k == ea);
                            @(posedge clk); #1;
                        end
                        tx_error           = 1'b0;
                        tx_transfer_active = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Transaction view: a pending command ages while waiting for txcu, a transfer runs
    // until active drops, then a quiet period must elapse before the next grant.
    logic [2:0] m_pend;
    int         m_age;
    bit         m_xfer, m_err, m_tog, m_sent;
    int         m_gap;
    logic [2:0] e_pkt;
    logic       e_hsg, e_dg, e_done, e_serr, e_busy;

    always @(negedge clk) begin
        if (n_rst !== 1'b1) begin
            m_pend = 3'd0; m_age = 0; m_xfer = 0; m_err = 0; m_gap = 0;
            m_tog = 0; m_sent = 0;
            e_pkt = 3'd0; e_hsg = 0; e_dg = 0; e_done = 0; e_serr = 0; e_busy = 0;
            check3("pkt", tx_packet, e_pkt);
            check1("busy", busy, e_busy);
            check1("hs_grant", hs_grant, e_hsg);
            check1("data_grant", data_grant, e_dg);
            check1("done", done, e_done);
            check1("sched_error", sched_error, e_serr);
        end else begin
            logic [2:0] n_pkt;
            bit hsg, dg, dn, se;
            check3("pkt", tx_packet, e_pkt);
            check1("busy", busy, e_busy);
            check1("hs_grant", hs_grant, e_hsg);
            check1("data_grant", data_grant, e_dg);
            check1("done", done, e_done);
            check1("sched_error", sched_error, e_serr);

            n_pkt = e_pkt; hsg = 0; dg = 0; dn = 0; se = 0;
            if (m_xfer) begin
                if (!tx_transfer_active) begin
                    dn = 1; se = m_err | tx_error; m_err = 0; m_xfer = 0; m_gap = GAP_LEN;
                end else if (tx_error) begin
                    m_err = 1;
                end
            end else if (m_pend != 3'd0) begin
                m_age++;
                if (tx_transfer_active && e_pkt != 3'd0) begin
                    m_xfer = 1; m_pend = 3'd0; n_pkt = 3'd0;
                end else if (m_age >= STO) begin
                    se = 1; m_pend = 3'd0; n_pkt = 3'd0; m_gap = GAP_LEN;
                end else begin
                    n_pkt = m_pend;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (hs_req) begin
                m_pend = hs_type; m_age = 0; hsg = 1;
            end else if (data_req && buffer_occupancy >= data_len) begin
                m_pend = m_tog ? 3'd3 : 3'd2; m_age = 0; dg = 1;
            end

            if (clr_toggle) begin
                m_tog = 0; m_sent = 0;
            end else begin
                if (rx_ack && m_sent) begin
                    m_tog = !m_tog; m_sent = 0;
                end
                if (dg) m_sent = 1;
            end

            e_pkt = n_pkt; e_hsg = hsg; e_dg = dg; e_done = dn; e_serr = se;
            e_busy = !(m_pend == 3'd0 && !m_xfer && m_gap == 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return hs_grant;
            1:       return data_grant;
            2:       return done;
            default: return sched_error;
        endcase
    endfunction

    task automatic wait_pulse(input string name, input int which, input int bound, output int n);
        n = 0;
        while (sig_of(which) !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check1(name, sig_of(which), 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check1("wait_idle", busy, 1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int n;
        n_rst = 1'b0; hs_req = 0; hs_type = 3'd4; data_req = 0; data_len = '0;
        buffer_occupancy = '0; rx_ack = 0; clr_toggle = 0;
        repeat (3) tick();
        check3("rst_pkt", tx_packet, 3'd0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        tick();
        n_rst = 1'b1;
        tick();

        // Handshake ACK: command shown two cycles, done once, next grant after the gap.
        hs_type = 3'd4; hs_req = 1;
        tick();
        check1("t1_hs_grant", hs_grant, 1'b1);
        check3("t1_pkt_not_yet", tx_packet, 3'd0);
        hs_req = 0;
        tick();
        check1("t1_grant_one_pulse", hs_grant, 1'b0);
        check3("t1_pkt_ack_a", tx_packet, 3'd4);
        tick();
        check3("t1_pkt_ack_b", tx_packet, 3'd4);
        tick();
        check3("t1_pkt_out", tx_packet, 3'd0);
        check1("t1_busy", busy, 1'b1);
        wait_pulse("t1_done", 2, 60, n);
        checkn("t1_done_latency", n, 20);
        hs_req = 1;
        wait_pulse("t1_regrant", 0, 60, n);
        checkn("t1_gap_spacing", n, GAP + 1);
        hs_req = 0;
        wait_idle();

        // Simultaneous requests: handshake first, DATA0 only after the gap.
        hs_type = 3'd4; hs_req = 1; data_req = 1; data_len = 7'd2; buffer_occupancy = 7'd2;
        tick();
        check1("t2_hs_first", hs_grant, 1'b1);
        check1("t2_data_waits", data_grant, 1'b0);
        hs_req = 0;
        wait_pulse("t2_data_grant", 1, 100, n);
        checkn("t2_data_after_gap", n, 40);
        data_req = 0;
        tick();
        check3("t2_pkt_data0", tx_packet, 3'd2);
        wait_idle();

        // Occupancy below length blocks the grant until it catches up.
        data_len = 7'd4; buffer_occupancy = 7'd3; data_req = 1;
        repeat (4) begin
            tick();
            check1("t3_no_grant", data_grant, 1'b0);
        end
        buffer_occupancy = 7'd4;
        tick();
        check1("t3_grant", data_grant, 1'b1);
        data_req = 0;
        tick();
        check3("t3_pkt_data0", tx_packet, 3'd2);
        wait_idle();

        // rx_ack flips the toggle, clr_toggle forces it back.
        rx_ack = 1; tick(); rx_ack = 0;
        data_req = 1;
        tick();
        check1("t4_grant_a", data_grant, 1'b1);
        data_req = 0;
        tick();
        check3("t4_pkt_data1", tx_packet, 3'd3);
        wait_idle();
        clr_toggle = 1; tick(); clr_toggle = 0;
        data_req = 1;
        tick();
        check1("t4_grant_b", data_grant, 1'b1);
        data_req = 0;
        tick();
        check3("t4_pkt_data0_after_clr", tx_packet, 3'd2);
        wait_idle();

        // txcu never answers: timeout error, no done.
        force_mute = 1;
        hs_type = 3'd5; hs_req = 1;
        tick();
        check1("t5_hs_grant", hs_grant, 1'b1);
        hs_req = 0;
        wait_pulse("t5_timeout", 3, 30, n);
        checkn("t5_timeout_latency", n, STO);
        check3("t5_pkt_out_on_error", tx_packet, 3'd0);
        check1("t5_no_done", done, 1'b0);
        force_mute = 0;
        wait_idle();
        txcu_err = 1;
        hs_type = 3'd4; hs_req = 1;
        tick();
        hs_req = 0;
        wait_pulse("t5_err_done", 2, 60, n);
        check1("t5_err_with_done", sched_error, 1'b1);
        txcu_err = 0;
        wait_idle();

        // Reset while ACTIVE: outputs drop at once and the toggle returns to 0.
        rx_ack = 1; tick(); rx_ack = 0;
        hs_type = 3'd6; hs_req = 1;
        tick();
        hs_req = 0;
        for (int k = 0; k < 20 && !tx_transfer_active; k++) tick();
        check1("t6_active_seen", tx_transfer_active, 1'b1);
        tick();
        check1("t6_busy_before", busy, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        check3("t6_pkt_async", tx_packet, 3'd0);
        check1("t6_busy_async", busy, 1'b0);
        check1("t6_done_async", done, 1'b0);
        tick();
        tick();
        n_rst = 1'b1;
        data_len = 7'd4; buffer_occupancy = 7'd4; data_req = 1;
        tick();
        check1("t6_grant_after_rst", data_grant, 1'b1);
        data_req = 0;
        tick();
        check3("t6_toggle_reset", tx_packet, 3'd2);
        wait_idle();

        // Randomized traffic, checked every cycle by the model.
        rand_txcu = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (hs_req && hs_grant) hs_req = 0;
            if (data_req && data_grant) data_req = 0;
            if (!hs_req && $urandom_range(0, 15) == 0) begin
                hs_req = 1;
                case ($urandom_range(0, 2))
                    0:       hs_type = 3'd4;
                    1:       hs_type = 3'd5;
                    default: hs_type = 3'd6;
                endcase
            end
            if (!data_req && $urandom_range(0, 11) == 0) begin
                data_req = 1;
                data_len = 7'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 9) == 0) buffer_occupancy = 7'($urandom_range(0, 24));
            rx_ack     = ($urandom_range(0, 14) == 0);
            clr_toggle = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 1999) == 0) begin
                n_rst = 1'b0;
                tick();
                tick();
                n_rst = 1'b1;
            end
        end
        hs_req = 0; data_req = 0; rx_ack = 0; clr_toggle = 0;
        wait_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16, minimum idle clocks between the end of one transmitted packet and the start of the next.
REQ-002 SHALL have parameter START_TIMEOUT, default 8, maximum clocks from issuing tx_packet until tx_transfer_active rises.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; n_rst input 1, asynchronous active-low reset.
REQ-004 SHALL have ports: hs_req input 1, handshake request level held until granted.
REQ-005 hs_type input 3: tx_packet_type to send, one of ACK, NAK or STALL, valid while hs_req=1.
REQ-006 data_req input 1: data packet request level held until granted.
REQ-007 data_len input 7: number of payload bytes, valid while data_req=1.
REQ-008 buffer_occupancy input 7: byte count currently in the TX FIFO.
REQ-009 tx_transfer_active input 1 and tx_error input 1: status from txcu.
REQ-010 rx_ack input 1: one-cycle pulse indicating an ACK was received from the host.
REQ-011 clr_toggle input 1: one-cycle pulse forcing the data toggle to 0.
REQ-012 tx_packet output 3: packet type command to txcu; OUT (3'b000) means no request.
REQ-013 hs_grant output 1 and data_grant output 1: one-cycle pulses acknowledging the accepted requester.
REQ-014 done output 1 and sched_error output 1: one-cycle completion and failure pulses.
REQ-015 busy output 1: high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, ISSUE, ACTIVE and GAP.
REQ-017 IDLE, hs_req=1: the block SHALL latch hs_type, pulse hs_grant, and go to ISSUE next cycle.
REQ-018 Handshake priority: when hs_req and data_req are both high in IDLE, the handshake SHALL win and data_req stays pending.
REQ-019 IDLE, data_req=1, hs_req=0, buffer_occupancy >= data_len: the block SHALL latch DATA0 if toggle=0 or DATA1 if toggle=1, pulse data_grant, go to ISSUE, and set the sent_data flag.
REQ-020 IDLE, data_req=1, buffer_occupancy < data_len: no grant; the block SHALL remain in IDLE.
REQ-021 In ISSUE, tx_packet SHALL equal the latched type and a timeout counter SHALL increment each clock.
REQ-022 ISSUE, tx_transfer_active=1: go to ACTIVE and drive tx_packet=OUT from the next cycle.
REQ-023 ISSUE, counter reaches START_TIMEOUT with no tx_transfer_active: pulse sched_error, drive tx_packet=OUT, go to GAP.
REQ-024 ACTIVE, tx_error=1: latch an error flag.
REQ-025 ACTIVE, tx_transfer_active falls: pulse done, and pulse sched_error in the same cycle if the error flag is set; clear the flag; go to GAP.
REQ-026 GAP SHALL count GAP_CYCLES clocks and then return to IDLE; requests arriving during GAP are not granted until IDLE.
REQ-027 Data toggle: rx_ack=1 while sent_data=1 SHALL invert toggle and clear sent_data; rx_ack in any other case SHALL be ignored.
REQ-028 clr_toggle SHALL set toggle=0 and clear sent_data in any state, with priority over a simultaneous rx_ack.
REQ-029 A toggle change SHALL never alter a packet type already latched.
REQ-030 Latency: request in IDLE at edge N gives grant asserted in cycle N and tx_packet valid from edge N+1.
REQ-031 Counters SHALL saturate and never wrap; START_TIMEOUT and GAP_CYCLES SHALL each fit an 8-bit counter.

Reset
REQ-032 On n_rst=0, asynchronously: state=IDLE, tx_packet=OUT, hs_grant=data_grant=done=sched_error=busy=0, toggle=0, sent_data=0, error flag=0, counters=0.
REQ-033 Reset mid-transfer SHALL abandon the packet with no done pulse; tx_packet is OUT immediately.

Structure
REQ-034 The tx_packet_type enum (OUT, IN, DATA0, DATA1, ACK, NAK, STALL) and the PID constants SHALL live in shared package usb_tx_pkg, imported by txcu and tx_scheduler.
REQ-035 The timeout and gap counting SHALL be one instance of sub-module sched_timer (clear, enable, 8-bit saturating count, terminal-count compare).

Verification
REQ-036 hs_req=1, hs_type=ACK; txcu model raises active 2 cycles later and holds 20 cycles -> hs_grant one pulse, tx_packet=ACK for 2 cycles then OUT, done once, next grant no earlier than 16 cycles later.
REQ-037 hs_req and data_req rise together, data_len=2, buffer_occupancy=2 -> ACK sent first; DATA0 granted only after the gap.
REQ-038 data_len=4, buffer_occupancy=3 -> no data_grant; raise occupancy to 4 -> data_grant next cycle, tx_packet=DATA0.
REQ-039 DATA0 sent, rx_ack pulse, second data_req -> tx_packet=DATA1; clr_toggle pulse, third request -> DATA0.
REQ-040 tx_transfer_active never rises -> sched_error pulse 8 cycles after ISSUE entry, no done, return to IDLE after the gap; tx_error during ACTIVE -> done and sched_error in the same cycle.
REQ-041 n_rst low while in ACTIVE -> all outputs at reset values immediately, toggle=0.
